// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver_if
// Description : Signal bundle between the 3-bit counter source, the
//               seg_scan_driver display stage and the board display pins.
//               master : counter side / observer (drives count)
//               slave  : seg_scan_driver (drives display pins and tally)
//   count    [2:0] counter value, slowly changing relative to clk
//   an       [3:0] digit anodes, active-low, an[i] selects digit i
//   seg      [6:0] segments, active-low, ordered {g,f,e,d,c,b,a}
//   dp             decimal point, active-low
//   wrap_bcd [7:0] wrap tally as {tens, units} BCD, 00-99
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if;
    logic [2:0] count;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] wrap_bcd;

    modport master (
        output count,
        input  an,
        input  seg,
        input  dp,
        input  wrap_bcd
    );

    modport slave (
        input  count,
        output an,
        output seg,
        output dp,
        output wrap_bcd
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Samples a free-running 3-bit counter, rejects one-cycle
//               glitches, keeps a BCD tally of 7->0 wrap-arounds and drives a
//               4-digit multiplexed active-low seven-segment display.
//               Digit 0 = counter, digit 1 = tally units, digit 2 = tally
//               tens, digit 3 = blank.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               bus  - seg_scan_driver_if.slave (count in; an, seg, dp,
//                      wrap_bcd out)
// Parameters  : REFRESH_DIV - clk cycles each digit stays selected (>= 2)
//               DP_HOLD     - clk cycles of the decimal-point pulse (>= 1)
// Options     : SEG_DP_PULSE_EN - when defined, each accepted counter change
//               lights the decimal point on digit 0 for DP_HOLD cycles;
//               otherwise dp is held at 1.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DP_HOLD     = 25000000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seg_scan_driver_if.slave   bus
);

    localparam logic [16:0] c_refresh_last = 17'(REFRESH_DIV - 1);
    localparam logic [6:0]  c_seg_blank    = 7'b1111111;

    // Parameter legality is checked at elaboration so a bad build fails early.
    if (REFRESH_DIV < 2 || DP_HOLD < 1) begin : g_param_check
        $error("seg_scan_driver: REFRESH_DIV must be >= 2 and DP_HOLD >= 1");
    end

    // ------------------------------------------------------------------------
    // Input capture and glitch filter
    // ------------------------------------------------------------------------
    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic [2:0] r_cnt_q;
    logic [3:0] r_units;
    logic [3:0] r_tens;

    logic w_accept;
    logic w_wrap;

    // s1 == s2 means the value survived two consecutive samples, which a
    // single-cycle pulse can never do.
    assign w_accept = (r_s1 == r_s2) && (r_s2 != r_cnt_q);
    assign w_wrap   = w_accept && (r_cnt_q == 3'd7) && (r_s2 == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 3'd0;
            r_s2    <= 3'd0;
            r_cnt_q <= 3'd0;
            r_units <= 4'd0;
            r_tens  <= 4'd0;
        end else begin
            r_s1 <= bus.count;
            r_s2 <= r_s1;
            if (w_accept) begin
                r_cnt_q <= r_s2;
            end
            if (w_wrap) begin
                if (r_units == 4'd9) begin
                    r_units <= 4'd0;
                    r_tens  <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
                end else begin
                    r_units <= r_units + 4'd1;
                end
            end
        end
    end

    assign bus.wrap_bcd = {r_tens, r_units};

    // ------------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------------
    logic [16:0] r_refresh;
    logic [1:0]  r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= 17'd0;
            r_idx     <= 2'd0;
        end else if (r_refresh == c_refresh_last) begin
            r_refresh <= 17'd0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_refresh <= r_refresh + 17'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Digit content and segment decode
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_seg7(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = c_seg_blank;
        endcase
        return pattern;
    endfunction

    logic [6:0] w_seg_next;

    always_comb begin
        w_seg_next = c_seg_blank;
        case (r_idx)
            2'd0:    w_seg_next = f_seg7({1'b0, r_cnt_q});
            2'd1:    w_seg_next = f_seg7(r_units);
            2'd2:    w_seg_next = f_seg7(r_tens);
            default: w_seg_next = c_seg_blank;
        endcase
    end

    logic [3:0] r_an;
    logic [6:0] r_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 4'b1110;
            r_seg <= 7'b1000000;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_seg_next;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;

    // ------------------------------------------------------------------------
    // Decimal-point pulse
    // ------------------------------------------------------------------------
`ifdef SEG_DP_PULSE_EN
    localparam logic [24:0] c_dp_hold = 25'(DP_HOLD);

    logic [24:0] r_dp_timer;
    logic        r_dp;

    // A change arriving mid-pulse restarts the full hold time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_timer <= 25'd0;
            r_dp       <= 1'b1;
        end else begin
            if (w_accept) begin
                r_dp_timer <= c_dp_hold;
            end else if (r_dp_timer != 25'd0) begin
                r_dp_timer <= r_dp_timer - 25'd1;
            end
            r_dp <= ~((r_idx == 2'd0) && (r_dp_timer != 25'd0));
        end
    end

    assign bus.dp = r_dp;
`else
    assign bus.dp = 1'b1;
`endif

endmodule
`default_nettype wire
